// File: rtl/alu.sv
// alu: 32-bit integer ALU with one registered result (latency 1, one op/cycle).
// Operations: ADD, SUB, MUL (low half), SRL, SLL, AND, OR, NOR, SLT.
// Optional build macro ALU_SIGNED_SLT_EN: when defined, SLT compares the
// operands as two's-complement signed values; otherwise SLT is unsigned.
module alu #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic [OPRN_WIDTH-1:0] oprn,
    output logic [DATA_WIDTH-1:0] result
);

    localparam logic [OPRN_WIDTH-1:0] OP_ADD = OPRN_WIDTH'(1);
    localparam logic [OPRN_WIDTH-1:0] OP_SUB = OPRN_WIDTH'(2);
    localparam logic [OPRN_WIDTH-1:0] OP_MUL = OPRN_WIDTH'(3);
    localparam logic [OPRN_WIDTH-1:0] OP_SRL = OPRN_WIDTH'(4);
    localparam logic [OPRN_WIDTH-1:0] OP_SLL = OPRN_WIDTH'(5);
    localparam logic [OPRN_WIDTH-1:0] OP_AND = OPRN_WIDTH'(6);
    localparam logic [OPRN_WIDTH-1:0] OP_OR  = OPRN_WIDTH'(7);
    localparam logic [OPRN_WIDTH-1:0] OP_NOR = OPRN_WIDTH'(8);
    localparam logic [OPRN_WIDTH-1:0] OP_SLT = OPRN_WIDTH'(9);

    // Shift amounts at or above this limit push every bit out of the word.
    localparam logic [DATA_WIDTH-1:0] SHIFT_LIM = DATA_WIDTH'(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] res_p0;
    logic                  lt_p0;

`ifdef ALU_SIGNED_SLT_EN
    logic signed [DATA_WIDTH-1:0] op1_s;
    logic signed [DATA_WIDTH-1:0] op2_s;

    // Signed less-than for SLT.
    always_comb begin
        op1_s = op1;
        op2_s = op2;
        lt_p0 = (op1_s < op2_s);
    end
`else
    // Unsigned less-than for SLT.
    always_comb begin
        lt_p0 = (op1 < op2);
    end
`endif

    // Stage p0: combinational operation select; undefined opcodes yield zero.
    always_comb begin
        res_p0 = '0;
        unique case (oprn)
            OP_ADD: res_p0 = op1 + op2;
            OP_SUB: res_p0 = op1 - op2;
            OP_MUL: res_p0 = op1 * op2;
            OP_SRL: res_p0 = (op2 >= SHIFT_LIM) ? '0 : (op1 >> op2);
            OP_SLL: res_p0 = (op2 >= SHIFT_LIM) ? '0 : (op1 << op2);
            OP_AND: res_p0 = op1 & op2;
            OP_OR:  res_p0 = op1 | op2;
            OP_NOR: res_p0 = ~(op1 | op2);
            OP_SLT: res_p0 = {{(DATA_WIDTH-1){1'b0}}, lt_p0};
            default: res_p0 = '0;
        endcase
    end

    // Stage p0 -> output: result register, cleared asynchronously so reset
    // also drops any computation in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            result <= '0;
        end else begin
            result <= res_p0;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu. A behavioural model (64-bit integer
// arithmetic and per-bit loops) predicts every registered result; a compare
// process checks the DUT on each falling edge, and directed vectors check
// literal expectations one cycle after each issue.
module tb_alu;

    logic        CLK;
    logic        RST;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [5:0]  oprn;
    logic [31:0] result;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] exp_res;
    logic        cmp_en = 1'b0;

    alu dut (
        .CLK    (CLK),
        .RST    (RST),
        .op1    (op1),
        .op2    (op2),
        .oprn   (oprn),
        .result (result)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam longint unsigned TWO32 = 64'h1_0000_0000;

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] op);
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint          sa;
        longint          sb;
        logic [31:0]     r = '0;
        case (op)
            6'd1: r = 32'((ua + ub) % TWO32);
            6'd2: r = 32'((ua + TWO32 - ub) % TWO32);
            6'd3: r = 32'((ua * ub) % TWO32);
            6'd4: r = (ub >= 32) ? 32'd0 : 32'(ua / (64'd1 << ub));
            6'd5: r = (ub >= 32) ? 32'd0 : 32'((ua * (64'd1 << ub)) % TWO32);
            6'd6: for (int i = 0; i < 32; i++) r[i] = a[i] && b[i];
            6'd7: for (int i = 0; i < 32; i++) r[i] = a[i] || b[i];
            6'd8: for (int i = 0; i < 32; i++) r[i] = !(a[i] || b[i]);
            6'd9: begin
`ifdef ALU_SIGNED_SLT_EN
                sa = a[31] ? longint'(ua) - longint'(TWO32) : longint'(ua);
                sb = b[31] ? longint'(ub) - longint'(TWO32) : longint'(ub);
`else
                sa = longint'(ua);
                sb = longint'(ub);
`endif
                r = (sa < sb) ? 32'd1 : 32'd0;
            end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
    endtask

    // Reference register: what result must hold after each edge or reset.
    always @(posedge CLK or posedge RST) begin
        if (RST) exp_res <= 32'd0;
        else     exp_res <= model(op1, op2, oprn);
    end

    // Compare process: every falling edge once checking is enabled.
    always @(negedge CLK) begin
        if (cmp_en) check("model", result, exp_res);
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op,
                         input logic [31:0] want, input string name);
        @(negedge CLK);
        op1 = a; op2 = b; oprn = op;
        @(posedge CLK);
        #1;
        check(name, result, want);
    endtask

    initial begin
        RST = 1'b1; op1 = 0; op2 = 0; oprn = 0;
        #1;
        check("reset_init", result, 32'd0);

        // Pin the model to a few hand-computed values.
        check("model_sub_wrap", model(32'd0, 32'd1, 6'd2), 32'hFFFF_FFFF);
        check("model_mul_hi", model(32'h1_0000, 32'h1_0000, 6'd3), 32'd0);
        check("model_nor", model(32'd6, 32'd9, 6'd8), 32'hFFFF_FFF0);
        check("model_sll32", model(32'd1, 32'd32, 6'd5), 32'd0);

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        cmp_en = 1'b1;

        // Reset mid-run
        issue(32'd15, 32'd3, 6'h01, 32'd18, "add_15_3");
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("rst_async", result, 32'd0);
        op1 = 32'd5; op2 = 32'd5; oprn = 6'h01;
        @(posedge CLK);
        #1;
        check("rst_held", result, 32'd0);
        @(negedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check("rst_released_pre_edge", result, 32'd0);
        @(posedge CLK);
        #1;
        check("rst_first_edge", result, 32'd10);

        // Arithmetic
        issue(32'd0,  32'd10, 6'h01, 32'd10, "add_0_10");
        issue(32'd17, 32'd0,  6'h01, 32'd17, "add_17_0");
        issue(32'd15, 32'd5,  6'h02, 32'd10, "sub_15_5");
        issue(32'd0,  32'd0,  6'h02, 32'd0,  "sub_0_0");
        issue(32'd5,  32'd5,  6'h02, 32'd0,  "sub_5_5");
        issue(32'd0,  32'd1,  6'h02, 32'hFFFF_FFFF, "sub_0_1");
        issue(32'd2,  32'd7,  6'h03, 32'd14, "mul_2_7");
        issue(32'd0,  32'd3,  6'h03, 32'd0,  "mul_0_3");
        issue(32'd5,  32'd0,  6'h03, 32'd0,  "mul_5_0");
        issue(32'h1_0000, 32'h1_0000, 6'h03, 32'd0, "mul_ovf");
        // Shifts
        issue(32'd4, 32'd1, 6'h04, 32'd2, "srl_4_1");
        issue(32'd4, 32'd2, 6'h04, 32'd1, "srl_4_2");
        issue(32'd4, 32'd3, 6'h04, 32'd0, "srl_4_3");
        issue(32'h8000_0000, 32'd40, 6'h04, 32'd0, "srl_40");
        issue(32'd3, 32'd1, 6'h05, 32'd6,  "sll_3_1");
        issue(32'd3, 32'd2, 6'h05, 32'd12, "sll_3_2");
        issue(32'd3, 32'd3, 6'h05, 32'd24, "sll_3_3");
        issue(32'd1, 32'd32, 6'h05, 32'd0, "sll_32");
        // Logic
        issue(32'd0, 32'd3, 6'h06, 32'd0,  "and_0_3");
        issue(32'd1, 32'd2, 6'h06, 32'd0,  "and_1_2");
        issue(32'd2, 32'd3, 6'h06, 32'd2,  "and_2_3");
        issue(32'd0, 32'd0, 6'h07, 32'd0,  "or_0_0");
        issue(32'd0, 32'd7, 6'h07, 32'd7,  "or_0_7");
        issue(32'd6, 32'd9, 6'h07, 32'd15, "or_6_9");
        issue(32'd1, 32'd0, 6'h08, 32'hFFFF_FFFE, "nor_1_0");
        issue(32'd0, 32'd0, 6'h08, 32'hFFFF_FFFF, "nor_0_0");
        issue(32'd6, 32'd9, 6'h08, 32'hFFFF_FFF0, "nor_6_9");
        // SLT
        issue(32'd4, 32'd5, 6'h09, 32'd1, "slt_4_5");
        issue(32'd1, 32'd1, 6'h09, 32'd0, "slt_1_1");
        issue(32'd2, 32'd1, 6'h09, 32'd0, "slt_2_1");
`ifdef ALU_SIGNED_SLT_EN
        issue(32'hFFFF_FFFF, 32'd1, 6'h09, 32'd1, "slt_neg1_1");
`else
        issue(32'hFFFF_FFFF, 32'd1, 6'h09, 32'd0, "slt_neg1_1");
`endif
        // Illegal opcodes
        issue(32'd7, 32'd9, 6'h00, 32'd0, "op_00");
        issue(32'd7, 32'd9, 6'h3F, 32'd0, "op_3f");
        issue(32'd7, 32'd9, 6'h0A, 32'd0, "op_0a");

        // Back-to-back through 0x01..0x09 plus randomized traffic; the
        // compare process checks each cycle against the model.
        for (int k = 0; k < 400; k++) begin
            @(negedge CLK);
            op1 = $urandom;
            op2 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            if (k < 27) oprn = 6'(1 + (k % 9));
            else if ($urandom_range(0, 9) == 0) oprn = 6'($urandom_range(0, 63));
            else oprn = 6'($urandom_range(1, 9));
        end
        @(negedge CLK);
        @(negedge CLK);
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
